// File: rtl/mac_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_ctrl_if
// Description : Strobe/handshake bundle between the MAC sequencer and datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface mac_seq_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              acc_clr;
  logic              acc_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              busy;
  logic              done;

  modport master (
    input  start,
    output rd_en, rd_addr, acc_clr, acc_en, wr_en, wr_addr, busy, done
  );

  modport slave (
    output start,
    input  rd_en, rd_addr, acc_clr, acc_en, wr_en, wr_addr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_seq_ctrl
// Description : Moore control FSM sequencing N_ELEM reads/accumulates + write.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl #(
  parameter int                N_ELEM   = 16,
  parameter int                ADDR_W   = 4,
  parameter int                MEM_LAT  = 1,
  parameter logic [ADDR_W-1:0] RES_ADDR = '0
) (
  input  wire logic      clk,
  input  wire logic      rst,
  mac_seq_ctrl_if.master bus
);

  localparam int                c_lat_w     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_lat_w-1:0] c_wait_init = c_lat_w'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0]  c_last_cnt  = ADDR_W'(N_ELEM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_ACC   = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [c_lat_w-1:0]  r_wcnt;
  logic                r_rd_en;
  logic                r_acc_clr;
  logic                r_acc_en;
  logic                r_wr_en;
  logic                r_busy;
  logic                r_done;

  // Strobes are registered alongside the state they belong to, so each one
  // is asserted for exactly the cycle its state is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_wcnt    <= '0;
      r_rd_en   <= 1'b0;
      r_acc_clr <= 1'b0;
      r_acc_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rd_en   <= 1'b0;
      r_acc_clr <= 1'b0;
      r_acc_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state   <= S_INIT;
            r_acc_clr <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_INIT: begin
          r_cnt   <= '0;
          r_state <= S_READ;
          r_rd_en <= 1'b1;
        end
        S_READ: begin
          r_wcnt  <= c_wait_init;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wcnt != '0) begin
            r_wcnt <= r_wcnt - c_lat_w'(1);
          end else begin
            r_state  <= S_ACC;
            r_acc_en <= 1'b1;
          end
        end
        S_ACC: begin
          // Terminal compare happens before any increment, so cnt never wraps.
          if (r_cnt == c_last_cnt) begin
            r_state <= S_WRITE;
            r_wr_en <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + ADDR_W'(1);
            r_state <= S_READ;
            r_rd_en <= 1'b1;
          end
        end
        S_WRITE: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_cnt;
  assign bus.acc_clr = r_acc_clr;
  assign bus.acc_en  = r_acc_en;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = RES_ADDR;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_seq_ctrl
// Description : Three parameterisations of mac_seq_ctrl vs. a run-timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;

  logic clk;
  logic rst;
  logic st [3];
  int   n_chk;
  int   n_err;
  int   cyc;

  bit   m_active [3];
  int   m_t0     [3];
  bit   m_fresh  [3];

  logic [13:0] obs [3];

  mac_seq_ctrl_if #(.ADDR_W(4)) i0 ();
  mac_seq_ctrl_if #(.ADDR_W(4)) i1 ();
  mac_seq_ctrl_if #(.ADDR_W(4)) i2 ();

  mac_seq_ctrl #(.N_ELEM(16), .ADDR_W(4), .MEM_LAT(1), .RES_ADDR(4'd0))
    u_dut0 (.clk(clk), .rst(rst), .bus(i0));
  mac_seq_ctrl #(.N_ELEM(1), .ADDR_W(4), .MEM_LAT(3), .RES_ADDR(4'd9))
    u_dut1 (.clk(clk), .rst(rst), .bus(i1));
  mac_seq_ctrl #(.N_ELEM(16), .ADDR_W(4), .MEM_LAT(2), .RES_ADDR(4'd15))
    u_dut2 (.clk(clk), .rst(rst), .bus(i2));

  assign i0.start = st[0];
  assign i1.start = st[1];
  assign i2.start = st[2];

  // {rd_en, acc_clr, acc_en, wr_en, busy, done, wr_addr, rd_addr}
  assign obs[0] = {i0.rd_en, i0.acc_clr, i0.acc_en, i0.wr_en, i0.busy, i0.done, i0.wr_addr, i0.rd_addr};
  assign obs[1] = {i1.rd_en, i1.acc_clr, i1.acc_en, i1.wr_en, i1.busy, i1.done, i1.wr_addr, i1.rd_addr};
  assign obs[2] = {i2.rd_en, i2.acc_clr, i2.acc_en, i2.wr_en, i2.busy, i2.done, i2.wr_addr, i2.rd_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pn(input int i);
    case (i)
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  function automatic int pl(input int i);
    case (i)
      1:       return 3;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int pr(input int i);
    case (i)
      1:       return 9;
      2:       return 15;
      default: return 0;
    endcase
  endfunction

  // Cycle offset (from the start-sampling edge) of the done pulse.
  function automatic int run_len(input int i);
    return pn(i) * (2 + pl(i)) + 3;
  endfunction

  function automatic bit m_idle(input int i, input int c);
    int d;
    d = c - m_t0[i];
    return !m_active[i] || d == 0 || d > run_len(i);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int  d, p, e, f, dl;
      bit  run, x_rd, x_acc;
      d   = cyc - m_t0[i];
      dl  = run_len(i);
      p   = 2 + pl(i);
      run = m_active[i] && d >= 1 && d <= dl;
      e   = d - 2;
      f   = d - 3 - pl(i);
      x_rd  = run && e >= 0 && (e % p) == 0 && (e / p) < pn(i);
      x_acc = run && f >= 0 && (f % p) == 0 && (f / p) < pn(i);
      check($sformatf("d%0d c%0d rd_en", i, cyc),   32'(obs[i][13]), 32'(x_rd));
      check($sformatf("d%0d c%0d acc_clr", i, cyc), 32'(obs[i][12]), 32'(run && d == 1));
      check($sformatf("d%0d c%0d acc_en", i, cyc),  32'(obs[i][11]), 32'(x_acc));
      check($sformatf("d%0d c%0d wr_en", i, cyc),   32'(obs[i][10]), 32'(run && d == dl - 1));
      check($sformatf("d%0d c%0d busy", i, cyc),    32'(obs[i][9]),  32'(run));
      check($sformatf("d%0d c%0d done", i, cyc),    32'(obs[i][8]),  32'(run && d == dl));
      if (x_rd)
        check($sformatf("d%0d c%0d rd_addr", i, cyc), 32'(obs[i][3:0]), 32'(e / p));
      else if (!run && m_fresh[i])
        check($sformatf("d%0d c%0d rd_addr_rst", i, cyc), 32'(obs[i][3:0]), 32'd0);
      if (run && d == dl - 1)
        check($sformatf("d%0d c%0d wr_addr", i, cyc), 32'(obs[i][7:4]), 32'(pr(i)));
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_active[i] = 1'b0;
        m_fresh[i]  = 1'b1;
      end else if (m_idle(i, cyc) && st[i] === 1'b1) begin
        m_active[i] = 1'b1;
        m_t0[i]     = cyc;
        m_fresh[i]  = 1'b0;
      end
    end
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic set_start(input logic v);
    for (int i = 0; i < 3; i++) st[i] = v;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_active[i] = 1'b0;
      m_t0[i]     = 0;
      m_fresh[i]  = 1'b0;
    end
    set_start(1'b0);

    // Reset and quiet idle
    repeat (2) step();
    rst = 1'b0;
    repeat (20) step();

    // Nominal run with extra starts landing mid-run and on the done cycle
    set_start(1'b1);
    step();
    for (int k = 1; k <= 60; k++) begin
      set_start(k == 10 || k == 51);
      step();
    end
    set_start(1'b0);
    repeat (10) step();

    // Reset mid-run, then a fresh full run
    set_start(1'b1);
    step();
    set_start(1'b0);
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    set_start(1'b1);
    step();
    set_start(1'b0);
    repeat (80) step();

    // Start held high: back-to-back runs
    set_start(1'b1);
    repeat (200) step();
    set_start(1'b0);
    repeat (80) step();

    // Randomised starts and occasional resets
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) st[i] = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    set_start(1'b0);
    repeat (80) step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
